mem_ls_ctrl: RTL and testbench
==============================

# mem_ls_ctrl

Parametrised load/store sequencer for the microcontroller datapath; next generation of the memory control FSM. It accepts a latched 16-bit LOAD/STORE instruction on a start strobe and drives the register-file, MAR/MDR and memory control strobes through address, data and write-back phases. It waits on a memory ready handshake bounded by a timeout, and reports completion with a one-cycle done/err pulse. Sits between the instruction decoder and the MAR/MDR/general-register bus.

## Interface
- NREG, 4, number of general registers; width of the one-hot rx_out/rx_in buses (2..32)
- WAIT_MAX, 8, max cycles to wait for mem_ready before timeout (>=1)
- clk  input  1  system clock, rising edge
- rst  input  1  reset; asynchronous and active-low
- start  input  1  request strobe; sampled only in IDLE
- instruction  input  16  [15:12] opcode, [11:6] param1 (data reg), [5:0] param2 (address reg)
- mem_ready  input  1  memory completes the current access this cycle
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse
- err  output  1  valid with done: 1 = operation aborted
- pc_inc, mar_in, mdr_write_en, mdr_read_en, mdr_out, mem_en, rw  output  1 each  datapath strobes (rw 1 = write)
- rx_out  output  NREG  one-hot register-to-bus enable
- rx_in  output  NREG  one-hot bus-to-register load enable

## Operation
- Opcodes: 4'b0010 LOAD (mem[R[param2]] -> R[param1]); 4'b0011 STORE (R[param1] -> mem[R[param2]]). Start with any other opcode is ignored: stays IDLE, no done.
- Register k maps to one-hot bit NREG-1-k (reg 0 -> MSB).
- On accepted start, instruction is latched; input changes afterwards have no effect. Start while busy is ignored.
- Illegal select (param1 >= NREG or param2 >= NREG): IDLE -> FAIL; no strobes asserted.
- States and outputs (unlisted outputs 0):
  - IDLE: all 0.
  - ADDR: pc_inc=1, rx_out=onehot(param2). -> MAR.
  - MAR: mar_in=1, rx_out=onehot(param2). -> SDATA (STORE) / LREQ (LOAD).
  - SDATA: rx_out=onehot(param1), mdr_write_en=1. -> SWRITE.
  - SWRITE: mem_en=1, rw=1. mem_ready -> DONE; timeout -> FAIL.
  - LREQ: mem_en=1, rw=0, mdr_read_en=mem_ready (combinational, only Mealy output). mem_ready -> LWB; timeout -> FAIL.
  - LWB: mdr_out=1, rx_in=onehot(param1). -> DONE.
  - DONE: done=1, err=0. -> IDLE.
  - FAIL: done=1, err=1. -> IDLE. No rx_in ever asserted on a failed LOAD.
- Wait counter: clog2(WAIT_MAX+1) bits, cleared on entry to SWRITE/LREQ, increments each cycle without mem_ready; timeout when counter == WAIT_MAX-1 and mem_ready low (WAIT_MAX wait cycles total). mem_ready on the timeout cycle wins (success).
- mem_ready outside SWRITE/LREQ is ignored.

## Timing
- Reset (rst low, asynchronous): state IDLE, latched instruction 0, counter 0, every output 0 immediately; mid-operation reset aborts with no done pulse.
- All outputs except mdr_read_en are registered-state decodes (Moore), glitch-free relative to clk.
- Start accepted at edge E0 -> ADDR during E0..E1.
- STORE, mem_ready high on first SWRITE cycle: ADDR, MAR, SDATA, SWRITE, DONE; done high in 5th cycle after E0; busy low in 6th. Each extra wait cycle adds one.
- LOAD, same: ADDR, MAR, LREQ, LWB, DONE; identical latency.
- Illegal select: FAIL in 1st cycle after E0; done=err=1 for that cycle.
- Timeout: FAIL follows the WAIT_MAXth memory cycle without ready.
- Back-to-back: start may be asserted in the cycle done is high; it is sampled at the following edge (IDLE), so minimum gap is one IDLE cycle.

## Test plan
- Reset: drive rst=0 mid-LREQ, outputs all 0 instantly; release, busy=0, no done.
- STORE 16'h30C2 (src R3, addr R2), NREG=4, mem_ready tied 1 -> rx_out 4'b0010 in ADDR/MAR, 4'b0001 in SDATA, mem_en=rw=1 one cycle, done=1/err=0 at cycle 5.
- LOAD 16'h2041 (dst R1, addr R1), mem_ready after 3 wait cycles -> mdr_read_en pulses with ready, rx_in=4'b0100 in LWB, done at cycle 8.
- LOAD with mem_ready never asserted, WAIT_MAX=8 -> exactly 8 LREQ cycles, then done=err=1, rx_in never nonzero.
- STORE 16'h3105 (addr reg 5 >= NREG) -> done=err=1 in cycle 1, pc_inc/mem_en never asserted; opcode 4'h5 start -> stays IDLE.
- Change instruction and pulse start during a LOAD -> ignored; original one-hot selects held; second start in done cycle accepted next edge.

Source files
------------

// File: rtl/mem_ls_ctrl.sv
// mem_ls_ctrl: load/store sequencer for the microcontroller datapath.
// Takes a latched 16-bit LOAD/STORE instruction on a start strobe and walks
// the register file, MAR/MDR and memory strobes through the address, data and
// write-back phases, waiting on mem_ready with a bounded timeout. Completion is
// reported as a single-cycle done pulse, with err flagging an aborted operation.

module mem_ls_ctrl #(
    parameter int NREG     = 4,
    parameter int WAIT_MAX = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [15:0]     instruction,
    input  logic            mem_ready,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            pc_inc,
    output logic            mar_in,
    output logic            mdr_write_en,
    output logic            mdr_read_en,
    output logic            mdr_out,
    output logic            mem_en,
    output logic            rw,
    output logic [NREG-1:0] rx_out,
    output logic [NREG-1:0] rx_in
);

    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_STORE = 4'b0011;

    // Wait counter holds 0..WAIT_MAX; the last legal wait cycle is WAIT_MAX-1.
    localparam int                 CNT_W    = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WAIT_MAX - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [31:0]        NREG_U   = NREG;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_MAR,
        S_SDATA,
        S_SWRITE,
        S_LREQ,
        S_LWB,
        S_DONE,
        S_FAIL
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [15:0]       instr_q;
    logic [CNT_W-1:0]  wait_cnt;

    // Fields of the incoming instruction, only looked at while IDLE.
    logic [3:0]        in_op;
    logic [5:0]        in_data_sel;
    logic [5:0]        in_addr_sel;
    logic              in_is_mem_op;
    logic              in_sel_legal;
    logic              start_ok;

    // Fields of the latched instruction that drive the rest of the operation.
    logic              is_store;
    logic [5:0]        data_sel;
    logic [5:0]        addr_sel;
    logic [NREG-1:0]   data_onehot;
    logic [NREG-1:0]   addr_onehot;

    logic              in_wait_state;
    logic              timed_out;

    // Register k drives one-hot bit NREG-1-k, so register 0 is the MSB.
    function automatic logic [NREG-1:0] sel_onehot(input logic [5:0] idx);
        logic [NREG-1:0] v;
        v = '0;
        for (int k = 0; k < NREG; k++) begin
            if (idx == 6'(k)) begin
                v[NREG-1-k] = 1'b1;
            end
        end
        return v;
    endfunction

    assign in_op        = instruction[15:12];
    assign in_data_sel  = instruction[11:6];
    assign in_addr_sel  = instruction[5:0];
    assign in_is_mem_op = (in_op == OP_LOAD) || (in_op == OP_STORE);
    assign in_sel_legal = ({26'd0, in_data_sel} < NREG_U) &&
                          ({26'd0, in_addr_sel} < NREG_U);

    // Unknown opcodes and starts while busy are simply dropped.
    assign start_ok     = (state_q == S_IDLE) && start && in_is_mem_op;

    assign is_store     = (instr_q[15:12] == OP_STORE);
    assign data_sel     = instr_q[11:6];
    assign addr_sel     = instr_q[5:0];
    assign data_onehot  = sel_onehot(data_sel);
    assign addr_onehot  = sel_onehot(addr_sel);

    assign in_wait_state = (state_q == S_SWRITE) || (state_q == S_LREQ);

    // A ready on the final wait cycle still counts as success.
    assign timed_out     = (wait_cnt == CNT_LAST) && !mem_ready;

    // State register; reset aborts any operation without a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the instruction only when a start is accepted so later input
    // changes cannot disturb the register selects mid-operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q <= '0;
        end else if (start_ok) begin
            instr_q <= instruction;
        end
    end

    // Count memory cycles without ready; held at zero outside the wait states
    // so it is already clear on entry to SWRITE or LREQ.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (in_wait_state) begin
            if (!mem_ready) begin
                wait_cnt <= wait_cnt + CNT_ONE;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    // Next-state sequencing through address, data and write-back phases.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = in_sel_legal ? S_ADDR : S_FAIL;
                end
            end
            S_ADDR:  state_d = S_MAR;
            S_MAR:   state_d = is_store ? S_SDATA : S_LREQ;
            S_SDATA: state_d = S_SWRITE;
            S_SWRITE: begin
                if (mem_ready) begin
                    state_d = S_DONE;
                end else if (timed_out) begin
                    state_d = S_FAIL;
                end
            end
            S_LREQ: begin
                if (mem_ready) begin
                    state_d = S_LWB;
                end else if (timed_out) begin
                    state_d = S_FAIL;
                end
            end
            S_LWB:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath strobes decoded from the registered state; only mdr_read_en
    // also looks at mem_ready so the MDR captures on the completing cycle.
    always_comb begin
        busy         = (state_q != S_IDLE);
        done         = 1'b0;
        err          = 1'b0;
        pc_inc       = 1'b0;
        mar_in       = 1'b0;
        mdr_write_en = 1'b0;
        mdr_read_en  = 1'b0;
        mdr_out      = 1'b0;
        mem_en       = 1'b0;
        rw           = 1'b0;
        rx_out       = '0;
        rx_in        = '0;
        case (state_q)
            S_ADDR: begin
                pc_inc = 1'b1;
                rx_out = addr_onehot;
            end
            S_MAR: begin
                mar_in = 1'b1;
                rx_out = addr_onehot;
            end
            S_SDATA: begin
                mdr_write_en = 1'b1;
                rx_out       = data_onehot;
            end
            S_SWRITE: begin
                mem_en = 1'b1;
                rw     = 1'b1;
            end
            S_LREQ: begin
                mem_en      = 1'b1;
                mdr_read_en = mem_ready;
            end
            S_LWB: begin
                mdr_out = 1'b1;
                rx_in   = data_onehot;
            end
            S_DONE: begin
                done = 1'b1;
            end
            S_FAIL: begin
                done = 1'b1;
                err  = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_ls_ctrl.sv
// tb_mem_ls_ctrl: directed bench for mem_ls_ctrl. Each operation pushes its
// hand-written per-cycle output trace into a queue; a monitor pops one entry
// for every cycle the DUT is busy or pulsing done and compares all outputs.

module tb_mem_ls_ctrl;

    localparam int NREG     = 4;
    localparam int WAIT_MAX = 8;

    // Control field order: busy done err pc_inc mar_in mdr_write_en
    // mdr_read_en mdr_out mem_en rw
    localparam logic [9:0] C_ADDR  = 10'b1001000000;
    localparam logic [9:0] C_MAR   = 10'b1000100000;
    localparam logic [9:0] C_SDATA = 10'b1000010000;
    localparam logic [9:0] C_SWR   = 10'b1000000011;
    localparam logic [9:0] C_LWAIT = 10'b1000000010;
    localparam logic [9:0] C_LRDY  = 10'b1000001010;
    localparam logic [9:0] C_LWB   = 10'b1000000100;
    localparam logic [9:0] C_DONE  = 10'b1100000000;
    localparam logic [9:0] C_FAIL  = 10'b1110000000;

    logic            clk;
    logic            rst;
    logic            start;
    logic [15:0]     instruction;
    logic            mem_ready;
    logic            busy;
    logic            done;
    logic            err;
    logic            pc_inc;
    logic            mar_in;
    logic            mdr_write_en;
    logic            mdr_read_en;
    logic            mdr_out;
    logic            mem_en;
    logic            rw;
    logic [NREG-1:0] rx_out;
    logic [NREG-1:0] rx_in;
    logic [17:0]     obs;

    logic [17:0]     exp_q[$];
    int              n_total = 0;
    int              n_bad   = 0;

    mem_ls_ctrl #(
        .NREG     (NREG),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .instruction  (instruction),
        .mem_ready    (mem_ready),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .pc_inc       (pc_inc),
        .mar_in       (mar_in),
        .mdr_write_en (mdr_write_en),
        .mdr_read_en  (mdr_read_en),
        .mdr_out      (mdr_out),
        .mem_en       (mem_en),
        .rw           (rw),
        .rx_out       (rx_out),
        .rx_in        (rx_in)
    );

    assign obs = {busy, done, err, pc_inc, mar_in, mdr_write_en, mdr_read_en,
                  mdr_out, mem_en, rw, rx_out, rx_in};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] mk(input logic [9:0] ctl, input logic [3:0] ro,
                                       input logic [3:0] ri);
        return {ctl, ro, ri};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_total++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Present one start pulse; returns one step into the first cycle after
    // the accepting edge.
    task automatic applyStimulus(input logic [15:0] instr);
        @(posedge clk);
        #1;
        instruction = instr;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDrain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        #1;
        checkOutput(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic expectAddrMar(input logic [3:0] a);
        exp_q.push_back(mk(C_ADDR, a, 4'b0000));
        exp_q.push_back(mk(C_MAR,  a, 4'b0000));
    endtask

    task automatic expectStore(input logic [3:0] a, input logic [3:0] s, input int waits);
        expectAddrMar(a);
        exp_q.push_back(mk(C_SDATA, s, 4'b0000));
        for (int i = 0; i <= waits; i++) begin
            exp_q.push_back(mk(C_SWR, 4'b0000, 4'b0000));
        end
        exp_q.push_back(mk(C_DONE, 4'b0000, 4'b0000));
    endtask

    task automatic expectLoad(input logic [3:0] a, input logic [3:0] d, input int waits);
        expectAddrMar(a);
        for (int i = 0; i < waits; i++) begin
            exp_q.push_back(mk(C_LWAIT, 4'b0000, 4'b0000));
        end
        exp_q.push_back(mk(C_LRDY, 4'b0000, 4'b0000));
        exp_q.push_back(mk(C_LWB,  4'b0000, d));
        exp_q.push_back(mk(C_DONE, 4'b0000, 4'b0000));
    endtask

    task automatic expectTimeout(input logic [3:0] a);
        expectAddrMar(a);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(mk(C_LWAIT, 4'b0000, 4'b0000));
        end
        exp_q.push_back(mk(C_FAIL, 4'b0000, 4'b0000));
    endtask

    // Monitor: every active cycle must match the next queued trace entry.
    initial begin
        logic [17:0] e_snap;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && (busy !== 1'b0 || done !== 1'b0)) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("[TB] FAIL unexpected_activity: got %h expected idle at %0t", obs, $time);
                end else begin
                    e_snap = exp_q.pop_front();
                    checkOutput("trace", 32'(obs), 32'(e_snap));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst         = 1'b0;
        start       = 1'b0;
        mem_ready   = 1'b0;
        instruction = 16'h0000;

        // Outputs during reset.
        #12;
        checkOutput("reset_outputs", 32'(obs), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // STORE R3 -> mem[R2], ready immediately.
        mem_ready = 1'b1;
        expectStore(4'b0010, 4'b0001, 0);
        applyStimulus(16'h30C2);
        waitDrain("store_drain", 20);
        mem_ready = 1'b0;

        // LOAD mem[R1] -> R1 with three wait cycles.
        expectLoad(4'b0100, 4'b0100, 3);
        applyStimulus(16'h2041);
        repeat (5) @(posedge clk);
        #1;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        waitDrain("load_wait_drain", 20);

        // LOAD with no ready: eight wait cycles then abort.
        expectTimeout(4'b0100);
        applyStimulus(16'h2041);
        waitDrain("timeout_drain", 30);

        // Illegal selects: both out of range, then only the data register.
        exp_q.push_back(mk(C_FAIL, 4'b0000, 4'b0000));
        applyStimulus(16'h3105);
        waitDrain("illegal_store_drain", 10);
        exp_q.push_back(mk(C_FAIL, 4'b0000, 4'b0000));
        applyStimulus(16'h2100);
        waitDrain("illegal_load_drain", 10);

        // Unsupported opcode is ignored.
        applyStimulus(16'h5041);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bad_opcode_busy", 32'(busy), 32'd0);

        // LOAD mem[R3] -> R2 with a disturbing start mid-op and a
        // back-to-back STORE requested during its done cycle.
        expectLoad(4'b0001, 4'b0010, 1);
        expectStore(4'b0010, 4'b0001, 0);
        applyStimulus(16'h2083);
        @(posedge clk);
        #1;
        start       = 1'b1;
        instruction = 16'h3105;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        start       = 1'b1;
        instruction = 16'h30C2;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        mem_ready = 1'b1;
        waitDrain("back_to_back_drain", 30);
        mem_ready = 1'b0;

        // Asynchronous reset in the middle of LREQ.
        expectAddrMar(4'b0100);
        exp_q.push_back(mk(C_LWAIT, 4'b0000, 4'b0000));
        exp_q.push_back(mk(C_LWAIT, 4'b0000, 4'b0000));
        applyStimulus(16'h2041);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("async_reset_outputs", 32'(obs), 32'd0);
        checkOutput("async_reset_queue", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("post_reset_busy", 32'(busy), 32'd0);
        checkOutput("post_reset_done", 32'(done), 32'd0);

        checkOutput("final_queue", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
